// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode encodings, SYS func3 codes and the control-unit state type.
package otter_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNC3_W  = 3;

  typedef enum logic [OPCODE_W-1:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    SYS    = 7'b1110011
  } opcode_t;

  localparam logic [FUNC3_W-1:0] F3_CSRRW = 3'b001;
  localparam logic [FUNC3_W-1:0] F3_MRET  = 3'b000;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    INTR  = 3'd4
  } cu_state_t;

endpackage

// File: rtl/cu_fsm.sv
// Multicycle control unit for the OTTER RV32I core: sequences fetch/exec/writeback/interrupt
// entry and counts retired instructions.
module cu_fsm
  import otter_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [OPCODE_W-1:0]        opcode,
  input  logic [FUNC3_W-1:0]         func3,
  input  logic                       intr,
  input  logic                       imem_ready,
  input  logic                       dmem_ready,
  output logic                       rst_out,
  output logic                       pcWrite,
  output logic                       regWrite,
  output logic                       memRDEN1,
  output logic                       memRDEN2,
  output logic                       memWE2,
  output logic                       csr_WE,
  output logic                       int_taken,
  output logic                       mret_exec,
  output logic [CNT_W-1:0]           instret
);

  cu_state_t state_q, state_d;
  logic      retire_c;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Next state and combinational control outputs
  always_comb begin
    state_d   = state_q;
    retire_c  = 1'b0;
    rst_out   = 1'b0;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    memWE2    = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;

    unique case (state_q)
      INIT: begin
        rst_out = 1'b1;
        state_d = FETCH;
      end

      FETCH: begin
        memRDEN1 = 1'b1;
        if (imem_ready) state_d = EXEC;
      end

      EXEC: begin
        case (opcode)
          LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
            pcWrite  = 1'b1;
            regWrite = 1'b1;
            retire_c = 1'b1;
          end
          BRANCH: begin
            pcWrite  = 1'b1;
            retire_c = 1'b1;
          end
          STORE: begin
            memWE2 = 1'b1;
            if (dmem_ready) begin
              pcWrite  = 1'b1;
              retire_c = 1'b1;
            end
          end
          LOAD: begin
            memRDEN2 = 1'b1;
            state_d  = WB;
          end
          SYS: begin
            pcWrite  = 1'b1;
            retire_c = 1'b1;
            if (func3 == F3_CSRRW) begin
              regWrite = 1'b1;
              csr_WE   = 1'b1;
            end else if (func3 == F3_MRET) begin
              mret_exec = 1'b1;
            end
          end
          // Unrecognised opcodes retire as a NOP
          default: begin
            pcWrite  = 1'b1;
            retire_c = 1'b1;
          end
        endcase
      end

      WB: begin
        memRDEN2 = 1'b1;
        if (dmem_ready) begin
          regWrite = 1'b1;
          pcWrite  = 1'b1;
          retire_c = 1'b1;
        end
      end

      INTR: begin
        int_taken = 1'b1;
        pcWrite   = 1'b1;
        state_d   = FETCH;
      end

      default: state_d = INIT;
    endcase

    // Interrupts are only taken at an instruction boundary
    if (retire_c) state_d = intr ? INTR : FETCH;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        instret <= '0;
    else if (retire_c) instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: per-instruction reference model predicts every cycle's controls.
module tb_cu_fsm;
  import otter_pkg::*;

  typedef struct packed {
    logic        rst_out;
    logic        pc;
    logic        rg;
    logic        rd1;
    logic        rd2;
    logic        we2;
    logic        csr;
    logic        it;
    logic        mret;
    logic [31:0] ir;
    logic [3:0]  ir4;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic        intr = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        rst_out, pcWrite, regWrite, memRDEN1, memRDEN2, memWE2, csr_WE, int_taken, mret_exec;
  logic [31:0] instret;
  logic        rst_out4, pcWrite4, regWrite4, memRDEN14, memRDEN24, memWE24, csr_WE4, int_taken4, mret_exec4;
  logic [3:0]  instret4;

  cu_fsm #(.CNT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .func3(func3), .intr(intr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .rst_out(rst_out), .pcWrite(pcWrite),
    .regWrite(regWrite), .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .memWE2(memWE2),
    .csr_WE(csr_WE), .int_taken(int_taken), .mret_exec(mret_exec), .instret(instret)
  );

  cu_fsm #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .func3(func3), .intr(intr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .rst_out(rst_out4), .pcWrite(pcWrite4),
    .regWrite(regWrite4), .memRDEN1(memRDEN14), .memRDEN2(memRDEN24), .memWE2(memWE24),
    .csr_WE(csr_WE4), .int_taken(int_taken4), .mret_exec(mret_exec4), .instret(instret4)
  );

  always #5 CLK = ~CLK;

  exp_t        sb[$];
  string       sb_name[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cnt     = 0;

  function automatic exp_t actual();
    exp_t a;
    a.rst_out = rst_out;  a.pc = pcWrite;   a.rg = regWrite;
    a.rd1 = memRDEN1;     a.rd2 = memRDEN2; a.we2 = memWE2;
    a.csr = csr_WE;       a.it = int_taken; a.mret = mret_exec;
    a.ir = instret;       a.ir4 = instret4;
    return a;
  endfunction

  task automatic cmp(input string nm, input exp_t a, input exp_t e);
    n_tests++;
    // The 4-bit instance's control outputs must match the 32-bit one
    if (a !== e || {rst_out4, pcWrite4, regWrite4, memRDEN14, memRDEN24, memWE24, csr_WE4,
                    int_taken4, mret_exec4} !== {e.rst_out, e.pc, e.rg, e.rd1, e.rd2, e.we2,
                    e.csr, e.it, e.mret}) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, a, e);
    end
  endtask

  // Monitor: the DUT presents a control word every cycle the scoreboard is active
  always @(negedge CLK) begin
    if (sb.size() > 0) cmp(sb_name.pop_front(), actual(), sb.pop_front());
  end

  function automatic logic pick(input int bg);
    return (bg == 2) ? 1'($urandom) : 1'(bg);
  endfunction

  // Drive one cycle of inputs and queue the expected controls for it
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic ir_rdy,
                     input logic dm_rdy, input logic irq, input exp_t e, input string nm);
    @(posedge CLK); #1;
    opcode = op; func3 = f3; imem_ready = ir_rdy; dmem_ready = dm_rdy; intr = irq;
    e.ir  = cnt;
    e.ir4 = cnt[3:0];
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  // Instruction-level reference: control word of a single-cycle EXEC for a non-memory opcode
  function automatic exp_t exec_word(input logic [6:0] op, input logic [2:0] f3);
    exp_t e = '0;
    e.pc = 1'b1;
    if (op == LUI || op == AUIPC || op == JAL || op == JALR || op == OP_IMM || op == OP_RG3)
      e.rg = 1'b1;
    else if (op == SYS && f3 == 3'b001) begin
      e.rg = 1'b1; e.csr = 1'b1;
    end else if (op == SYS && f3 == 3'b000)
      e.mret = 1'b1;
    return e;
  endfunction

  // One instruction: fw fetch waits, mw data waits, take = intr at the retire cycle,
  // bg = intr level elsewhere (0, 1, or 2 for random)
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                          input int mw, input logic take, input int bg, input string nm);
    exp_t e;
    for (int w = 0; w <= fw; w++) begin
      e = '0; e.rd1 = 1'b1;
      cyc(7'($urandom), 3'($urandom), w == fw, 1'($urandom), pick(bg), e, {nm, "_fetch"});
    end
    if (op == LOAD) begin
      e = '0; e.rd2 = 1'b1;
      cyc(op, f3, 1'($urandom), 1'($urandom), pick(bg), e, {nm, "_exec"});
      for (int w = 0; w <= mw; w++) begin
        e = '0; e.rd2 = 1'b1;
        if (w == mw) begin e.rg = 1'b1; e.pc = 1'b1; end
        cyc(op, f3, 1'($urandom), w == mw, (w == mw) ? take : pick(bg), e, {nm, "_wb"});
      end
    end else if (op == STORE) begin
      for (int w = 0; w <= mw; w++) begin
        e = '0; e.we2 = 1'b1;
        if (w == mw) e.pc = 1'b1;
        cyc(op, f3, 1'($urandom), w == mw, (w == mw) ? take : pick(bg), e, {nm, "_exec"});
      end
    end else begin
      cyc(op, f3, 1'($urandom), 1'($urandom), take, exec_word(op, f3), {nm, "_exec"});
    end
    cnt++;
    if (take) begin
      e = '0; e.it = 1'b1; e.pc = 1'b1;
      cyc(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), pick(bg), e, {nm, "_intr"});
    end
  endtask

  task automatic release_reset();
    exp_t e;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    cnt   = 0;
    e = '0; e.rst_out = 1'b1;
    sb.push_back(e);
    sb_name.push_back("init");
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [11];
    ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_RG3, SYS, 7'h00};
    return ops[$urandom_range(10, 0)];
  endfunction

  initial begin
    exp_t e;
    // Reset held: INIT outputs and cleared counter
    repeat (2) @(posedge CLK);
    #1;
    e = '0; e.rst_out = 1'b1;
    cmp("reset_hold", actual(), e);

    release_reset();
    do_instr(OP_IMM, 3'b000, 0, 0, 1'b0, 0, "addi");
    do_instr(SYS, 3'b001, 0, 0, 1'b0, 0, "csrrw");
    do_instr(LOAD, 3'b010, 0, 3, 1'b0, 0, "lw");
    do_instr(STORE, 3'b010, 0, 2, 1'b0, 0, "sw");
    do_instr(BRANCH, 3'b000, 1, 0, 1'b1, 1, "beq_irq");
    do_instr(SYS, 3'b000, 0, 0, 1'b0, 0, "mret");
    do_instr(7'h00, 3'b000, 0, 0, 1'b0, 0, "illegal");

    for (int i = 0; i < 60; i++)
      do_instr(rand_op(), 3'($urandom_range(7, 0) < 3 ? $urandom_range(1, 0) : $urandom),
               $urandom_range(2, 0), $urandom_range(3, 0), ($urandom_range(3, 0) == 0), 2, "rnd");

    // Reset in the middle of a load writeback wait
    do_instr(OP_IMM, 3'b000, 0, 0, 1'b0, 0, "pre_ld");
    e = '0; e.rd1 = 1'b1;
    cyc(7'h00, 3'b000, 1'b1, 1'b0, 1'b0, e, "ld2_fetch");
    e = '0; e.rd2 = 1'b1;
    cyc(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, e, "ld2_exec");
    cyc(LOAD, 3'b010, 1'b0, 1'b0, 1'b0, e, "ld2_wb");
    @(posedge CLK); #1;
    opcode = LOAD; dmem_ready = 1'b0;
    #1;
    e = '0; e.rd2 = 1'b1; e.ir = cnt; e.ir4 = cnt[3:0];
    cmp("wb_before_rst", actual(), e);
    RST_N = 1'b0;
    #1;
    e = '0; e.rst_out = 1'b1;
    cmp("async_rst", actual(), e);
    repeat (2) @(posedge CLK);

    // 17 retires on the 4-bit counter
    release_reset();
    for (int i = 0; i < 17; i++)
      do_instr(OP_RG3, 3'b000, 0, 0, 1'b0, 0, "wrap");
    @(posedge CLK); #1;
    n_tests++;
    if (instret4 !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap4: got %0d want 1", instret4);
    end
    @(negedge CLK);
    @(negedge CLK);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_fsm.md
# cu_fsm

Multicycle sequencer for the OTTER RV32I core. It steps each instruction through fetch, execute, optional load writeback and interrupt entry. It drives the write and read enables for the PC, register file, CSR file and both memory ports. It sits beside the combinational decoder: it supplies `int_taken`, which forces the decoder to select the trap vector, and it keeps a retired-instruction count.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `opcode` in 7: ir[6:0].
- `func3` in 3: ir[14:12].
- `intr` in 1: interrupt request, already gated by CSR MIE.
- `imem_ready` in 1: instruction word valid this cycle.
- `dmem_ready` in 1: data read or write complete this cycle.
- `rst_out` out 1: synchronous clear to the PC and register file.
- `pcWrite` out 1: PC register load.
- `regWrite` out 1: register file write.
- `memRDEN1` out 1: instruction port read enable.
- `memRDEN2` out 1: data port read enable.
- `memWE2` out 1: data port write enable.
- `csr_WE` out 1: CSR write.
- `int_taken` out 1: interrupt entry. This also goes to the decoder so that pcSource is 100.
- `mret_exec` out 1: MRET executing.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States are INIT, FETCH, EXEC, WB and INTR.
- While RST_N is low, the state is INIT and `instret` is 0.
- INIT:
  - `rst_out` is 1.
  - Go to FETCH on the next edge.
- FETCH:
  - `memRDEN1` is 1.
  - Stay in FETCH while `imem_ready` is 0.
  - Go to EXEC on `imem_ready`=1.
- EXEC outputs depend on `opcode`:
  - LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: `pcWrite`=1 and `regWrite`=1. This is a retire.
  - BRANCH: `pcWrite`=1. This is a retire.
  - STORE: `memWE2`=1, held until `dmem_ready`. In the `dmem_ready` cycle, `pcWrite`=1 and the instruction retires.
  - LOAD: `memRDEN2`=1 and `pcWrite`=0. Go to WB.
  - SYS with `func3`=001 (CSRRW): `regWrite`=1, `csr_WE`=1 and `pcWrite`=1. This is a retire.
  - SYS with `func3`=000 (MRET): `mret_exec`=1 and `pcWrite`=1. This is a retire.
  - SYS with any other `func3`, or an unlisted opcode: `pcWrite`=1 only, as a NOP. This is a retire.
- WB:
  - `memRDEN2` stays 1 until `dmem_ready`.
  - In the `dmem_ready` cycle, `regWrite`=1 and `pcWrite`=1, and the instruction retires.
- Retire cycle exit:
  - Go to INTR if `intr`=1 is sampled in that same cycle.
  - Otherwise go to FETCH.
- INTR:
  - `int_taken`=1 and `pcWrite`=1. The PC loads mtvec and the CSR block saves mepc.
  - Always go to FETCH, regardless of `intr`.
- Interrupt sampling:
  - `intr` is sampled only in a retire cycle.
  - It is ignored in FETCH, in wait cycles, and in INIT.
  - An instruction in progress is never aborted.
- `instret`:
  - Increments by 1 on each retire edge.
  - INTR cycles do not count.
  - It wraps modulo 2^CNT_W.
- Every output not listed for a state is 0.

## Timing
- `instret` is the only registered output. All other outputs are combinational from the state and the current inputs: `opcode`, `func3`, `dmem_ready`, `imem_ready`.
- Minimum cycles per instruction, with memories ready:
  - 2 for non-load instructions: FETCH then EXEC.
  - 3 for loads: FETCH, EXEC, WB.
  - Interrupt entry adds 1.
- Each cycle of `imem_ready`=0 or `dmem_ready`=0 adds exactly one wait cycle. Enables stay asserted and stable throughout the wait.
- `opcode` and `func3` must be stable from the EXEC entry edge through the WB exit. The IR is loaded at the end of FETCH.
- Reset asserted in any state:
  - The state goes to INIT immediately, asynchronously.
  - All enables drop in the same instant, and `rst_out` rises.
  - `instret` clears.
- Reset release: the first edge with RST_N=1 holds INIT for that cycle, then the design enters FETCH.

## Structure
- The shared package `otter_pkg` holds:
  - `opcode_t`, the same encodings used by the decoder.
  - The `func3` SYS constants: CSRRW=001, MRET=000.
  - `cu_state_t` with values INIT, FETCH, EXEC, WB, INTR.
- No sub-module. The state register, the next-state/output `always_comb`, and the counter are all in one module.
- State decode uses a `unique case`. An illegal state recovers to INIT.

## Test plan
- Reset and CSR write:
  - Stimulus: reset, then release; memories always ready; feed ADDI (0010011), then CSRRW (1110011, func3=001).
  - Required: `rst_out` for 1 cycle, then fetch.
  - Required: the ADDI EXEC cycle asserts `pcWrite` and `regWrite`.
  - Required: the CSRRW EXEC cycle asserts `pcWrite`, `regWrite` and `csr_WE`.
  - Required: `instret`=2 after 5 edges.
- Load with wait:
  - Stimulus: LW (0000011) with `dmem_ready` low for 3 cycles.
  - Required: WB lasts 4 cycles with `memRDEN2`=1 throughout.
  - Required: `regWrite` and `pcWrite` only in the last WB cycle.
- Store with wait:
  - Stimulus: SW (0100011) with `dmem_ready` low for 2 cycles.
  - Required: `memWE2` is 1 for 3 EXEC cycles.
  - Required: `pcWrite` only in the third.
  - Required: `regWrite` never asserts.
- Interrupt entry:
  - Stimulus: `intr`=1 held during FETCH and the EXEC of BEQ.
  - Required: INTR follows EXEC, with `int_taken`=1 and `pcWrite`=1 for 1 cycle, then FETCH.
  - Required: `instret` counts the BEQ only.
  - Required: `intr` still high in INTR does not cause a second INTR.
- MRET and illegal opcode:
  - Stimulus: MRET (1110011, func3=000), then opcode 0000000.
  - Required: MRET asserts `mret_exec`=1 and `pcWrite`=1.
  - Required: the illegal opcode asserts `pcWrite` only.
  - Required: both retire.
- Reset mid-operation and counter wrap:
  - Stimulus: RST_N low mid-WB.
  - Required: all enables go to 0 and `rst_out`=1 without a clock edge; `instret`=0.
  - Stimulus: with CNT_W=4, retire 17 instructions.
  - Required: `instret`=1 after the wrap.
